// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// Module: lsu
// Purpose:
//   Load/store unit that sits right after the execute stage. Memory ops
//   issue a single request on an SRAM-style data bus, wait for the response,
//   then align and sign/zero-extend load data. Non-memory ops pass the
//   execute result straight through. Results go to write-back through a
//   valid/ready handshake.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   in_valid_i/ready_o  handshake with execute (ready only when idle)
//   is_load_i/store_i   op kind (both high is treated as a load)
//   func3_i             RV32 width/sign code
//   res_i, wdata_i      execute result (address or value) and rs2 store data
//   req_*               single-channel bus request (held stable until ready)
//   rsp_*               bus response (one-cycle pulse, always accepted)
//   out_valid_o/ready_i handshake with write-back
//   wb_data_o           load data / pass-through value; 0 for stores and errors
//   err_misalign_o      misaligned address or illegal funct3 (no bus access)
//   err_bus_o           bus returned an error for this op
// ---------------------------------------------------------------------------
module lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        func3_i,
    input  logic [XLEN-1:0]   res_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_wen_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [XLEN-1:0]   req_wdata_o,
    output logic [3:0]        req_wmask_o,
    input  logic              rsp_valid_i,
    input  logic [XLEN-1:0]   rsp_rdata_i,
    input  logic              rsp_err_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              err_misalign_o,
    output logic              err_bus_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        r_state;
    logic              r_isLoad;
    logic [2:0]        r_func3;
    logic [1:0]        r_offset;
    logic [ADDR_W-3:0] r_wordAddr;
    logic              r_wen;
    logic [XLEN-1:0]   r_wdata;
    logic [3:0]        r_wmask;
    logic [XLEN-1:0]   r_wbData;
    logic              r_errMis;
    logic              r_errBus;

    logic              w_isMem;
    logic              w_illegal;
    logic              w_misalign;
    logic [3:0]        w_mask;
    logic [XLEN-1:0]   w_rspShifted;
    logic [XLEN-1:0]   w_loadData;

    // Decode the incoming op while idle: legality of funct3, alignment of
    // the effective address, and the byte-strobe pattern for stores.
    // Illegal funct3 is reported through the same flag as misalignment.
    always_comb begin
        w_isMem    = is_load_i | is_store_i;
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        w_mask     = 4'b1111;
        if (is_load_i) begin
            w_illegal = (func3_i == 3'b011) || (func3_i == 3'b110) || (func3_i == 3'b111);
        end else begin
            w_illegal = func3_i[2] || (func3_i[1:0] == 2'b11);
        end
        case (func3_i[1:0])
            2'b01:   w_misalign = res_i[0];
            2'b10:   w_misalign = (res_i[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
        case (func3_i[1:0])
            2'b00:   w_mask = 4'b0001 << res_i[1:0];
            2'b01:   w_mask = 4'b0011 << res_i[1:0];
            default: w_mask = 4'b1111;
        endcase
    end

    // Bring the addressed byte/halfword down to bit 0, then extend it
    // according to the latched width/sign code.
    always_comb begin
        w_rspShifted = rsp_rdata_i >> {r_offset, 3'b000};
        w_loadData   = w_rspShifted;
        case (r_func3)
            3'b000:  w_loadData = {{(XLEN-8){w_rspShifted[7]}}, w_rspShifted[7:0]};
            3'b100:  w_loadData = {{(XLEN-8){1'b0}}, w_rspShifted[7:0]};
            3'b001:  w_loadData = {{(XLEN-16){w_rspShifted[15]}}, w_rspShifted[15:0]};
            3'b101:  w_loadData = {{(XLEN-16){1'b0}}, w_rspShifted[15:0]};
            default: w_loadData = w_rspShifted;
        endcase
    end

    // Main sequencer. Everything the bus and write-back see is registered,
    // so there is no combinational path from req_ready_i to req_valid_o.
    // Responses outside WAIT are dropped, which also discards any stale
    // response belonging to an op that was cancelled by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_isLoad   <= 1'b0;
            r_func3    <= 3'b000;
            r_offset   <= 2'b00;
            r_wordAddr <= '0;
            r_wen      <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= 4'b0000;
            r_wbData   <= '0;
            r_errMis   <= 1'b0;
            r_errBus   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_isLoad   <= is_load_i;
                        r_func3    <= func3_i;
                        r_offset   <= res_i[1:0];
                        r_wordAddr <= res_i[ADDR_W-1:2];
                        r_wen      <= is_store_i & ~is_load_i;
                        r_wdata    <= wdata_i << {res_i[1:0], 3'b000};
                        r_wmask    <= w_mask;
                        r_wbData   <= '0;
                        r_errMis   <= 1'b0;
                        r_errBus   <= 1'b0;
                        if (!w_isMem) begin
                            r_wbData <= res_i;
                            r_state  <= DONE;
                        end else if (w_illegal || w_misalign) begin
                            r_errMis <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (req_ready_i) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid_i) begin
                        r_errBus <= rsp_err_i;
                        r_wbData <= (rsp_err_i || !r_isLoad) ? '0 : w_loadData;
                        r_state  <= DONE;
                    end
                end
                default: begin
                    if (out_ready_i) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready_o     = (r_state == IDLE);
    assign req_valid_o    = (r_state == REQ);
    assign req_wen_o      = r_wen;
    assign req_addr_o     = {r_wordAddr, 2'b00};
    assign req_wdata_o    = r_wdata;
    assign req_wmask_o    = r_wmask;
    assign out_valid_o    = (r_state == DONE);
    assign wb_data_o      = r_wbData;
    assign err_misalign_o = r_errMis;
    assign err_bus_o      = r_errBus;

endmodule
